if_id_pipe_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_entry_reg.sv | 34 +++
 rtl/if_id_pipe_stage.sv | 140 ++++++++++++++
 tb/tb_if_id_pipe_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the IF/ID pipeline stage.
//   state_t   - occupancy state of the stage (empty / one entry / main+skid)
//   NOP_MIPS  - default instruction presented by an empty slot
//   payload_w - width of the packed {pc, ins, sb} entry
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_MIPS = 32'h0000_0000;

  function automatic int payload_w(input int pc_w, input int ins_w, input int sb_w);
    return pc_w + ins_w + sb_w;
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: one pipeline entry {pc, ins, sb}.
// Ports:
//   clk, rst - clock and synchronous active-high reset (pc=0, ins=NOP, sb=0)
//   load     - capture d
//   clr      - replace the instruction field with NOP_INS, pc/sb held
//   d, q     - packed payload {pc, ins, sb}
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int                PC_W    = 32,
  parameter int                INS_W   = 32,
  parameter int                SB_W    = 1,
  parameter logic [INS_W-1:0]  NOP_INS = INS_W'(NOP_MIPS),
  localparam int               PW      = payload_w(PC_W, INS_W, SB_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clr,
  input  logic [PW-1:0] d,
  output logic [PW-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {PC_W'(0), NOP_INS, SB_W'(0)};
    end else if (clr) begin
      q[SB_W +: INS_W] <= NOP_INS;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_id_pipe_stage.sv
// if_id_pipe_stage: fetch-to-decode pipeline register with valid/ready
// handshake, optional skid entry, synchronous flush and a saturating
// stall counter.
// Ports:
//   clk, rst                        - clock, synchronous active-high reset
//   flush                           - drop all held and incoming entries
//   in_valid/in_ready, in_pc/ins/sb - fetch side
//   out_valid/out_ready, out_*      - decode side (out_ins = NOP_INS when invalid)
//   stall_cnt                       - cycles with in_valid=1 and in_ready=0
//
// state    | meaning
// ---------+----------------------------------------------
// ST_EMPTY | nothing held, out_ins shows NOP_INS
// ST_ONE   | main entry valid on out_*
// ST_FULL  | main on out_*, overflow in skid (SKID=1 only)
module if_id_pipe_stage
  import pipe_pkg::*;
#(
  parameter int               PC_W    = 32,
  parameter int               INS_W   = 32,
  parameter int               SB_W    = 1,
  parameter int               SKID    = 1,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_MIPS),
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [INS_W-1:0] in_ins,
  input  logic [SB_W-1:0]  in_sb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_ins,
  output logic [SB_W-1:0]  out_sb,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PW = payload_w(PC_W, INS_W, SB_W);

  state_t          state_q, state_d;
  logic            in_fire, out_fire;
  logic            main_load, main_clr, skid_load;
  logic [PW-1:0]   in_payload, main_d, main_q, skid_q;

  assign in_payload = {in_pc, in_ins, in_sb};

  // With a skid entry, in_ready comes straight from the state register so
  // fetch never sees a path from out_ready.
  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (SKID != 0) ? (state_q != ST_FULL)
                                 : ((state_q == ST_EMPTY) | out_ready);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_ONE;
        ST_ONE: begin
          if (in_fire && !out_fire && SKID != 0) state_d = ST_FULL;
          else if (!in_fire && out_fire)         state_d = ST_EMPTY;
        end
        ST_FULL:  if (out_fire) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    main_d    = in_payload;
    if (flush) begin
      main_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: main_load = in_fire;
        ST_ONE: begin
          // Without a skid, in_fire in ONE implies out_fire (in_ready=out_ready).
          if (in_fire && (out_fire || SKID == 0)) main_load = 1'b1;
          else if (in_fire)                       skid_load = 1'b1;
          else if (out_fire)                      main_clr  = 1'b1;
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: main_clr = 1'b1;
      endcase
    end
  end

  pipe_entry_reg #(
    .PC_W(PC_W), .INS_W(INS_W), .SB_W(SB_W), .NOP_INS(NOP_INS)
  ) u_main (
    .clk(clk), .rst(rst), .load(main_load), .clr(main_clr),
    .d(main_d), .q(main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_entry_reg #(
        .PC_W(PC_W), .INS_W(INS_W), .SB_W(SB_W), .NOP_INS(NOP_INS)
      ) u_skid (
        .clk(clk), .rst(rst), .load(skid_load), .clr(1'b0),
        .d(in_payload), .q(skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

  assign out_pc  = main_q[PW-1 -: PC_W];
  assign out_ins = main_q[SB_W +: INS_W];
  assign out_sb  = main_q[SB_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && !in_ready && !flush && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// tb_if_id_pipe_stage: drives a SKID=1/CNT_W=4 instance and a SKID=0/CNT_W=16
// instance with shared stimulus. Each instance is modelled as an ordered
// queue of capacity 2 (skid) or 1 (no skid); accepted entries are pushed
// at drive time and popped by a negedge monitor whenever the DUT consumes.
module tb_if_id_pipe_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_pc = '0, in_ins = '0;
  logic [0:0]  in_sb = '0;

  logic        ir [2];
  logic        ov [2];
  logic [31:0] opc [2];
  logic [31:0] oins [2];
  logic [0:0]  osb [2];
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;

  if_id_pipe_stage #(.SKID(1), .CNT_W(4)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]),
    .in_pc(in_pc), .in_ins(in_ins), .in_sb(in_sb),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_pc(opc[0]), .out_ins(oins[0]), .out_sb(osb[0]),
    .stall_cnt(cnt_a)
  );

  if_id_pipe_stage #(.SKID(0), .CNT_W(16)) dut_noskid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]),
    .in_pc(in_pc), .in_ins(in_ins), .in_sb(in_sb),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_pc(opc[1]), .out_ins(oins[1]), .out_sb(osb[1]),
    .stall_cnt(cnt_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        sb;
  } ent_t;

  ent_t sbq [2][$];
  bit   exp_ov [2];
  bit   exp_ir [2];
  int   exp_cnt [2];
  int   cnt_m [2];
  bit   clr_pend [2];
  bit   armed = 1'b0;
  int   checks = 0;
  int   failures = 0;

  function automatic int sat(input int i);
    return (i == 0) ? 15 : 65535;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // One cycle of stimulus; the reference model decides acceptance from its
  // own occupancy and queues what each instance should later emit.
  task automatic step(input bit r, input bit v, input bit fl, input bit ordy,
                      input logic [31:0] pc, input logic [31:0] ins, input bit sb);
    @(posedge clk);
    #1;
    if (r) ordy = 1'b0;
    rst = r; in_valid = v; flush = fl; out_ready = ordy;
    in_pc = pc; in_ins = ins; in_sb = sb;
    for (int i = 0; i < 2; i++) begin
      int sz;
      bit rdy;
      sz = sbq[i].size();
      rdy = (i == 0) ? (sz < 2) : (sz == 0 || ordy);
      exp_ov[i]  = (sz > 0);
      exp_ir[i]  = rdy;
      exp_cnt[i] = cnt_m[i];
      if (v && rdy && !fl && !r) sbq[i].push_back('{pc, ins, sb});
      if (r) cnt_m[i] = 0;
      else if (v && !rdy && !fl && cnt_m[i] < sat(i)) cnt_m[i]++;
      clr_pend[i] = r | fl;
    end
    armed = 1'b1;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 1'b0, ordy, 32'h0, 32'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    ent_t        e;
    logic [63:0] c;
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        c = (i == 0) ? 64'(cnt_a) : 64'(cnt_b);
        chk("in_ready", i, 64'(ir[i]), 64'(exp_ir[i]));
        chk("out_valid", i, 64'(ov[i]), 64'(exp_ov[i]));
        chk("stall_cnt", i, c, 64'(exp_cnt[i]));
        if (ov[i] !== 1'b1) chk("nop_when_invalid", i, 64'(oins[i]), 64'h0);
        if (ov[i] === 1'b1 && out_ready) begin
          if (sbq[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output dut%0d actual_pc=%0h required=none", i, opc[i]);
          end else begin
            e = sbq[i].pop_front();
            chk("out_pc", i, 64'(opc[i]), 64'(e.pc));
            chk("out_ins", i, 64'(oins[i]), 64'(e.ins));
            chk("out_sb", i, 64'(osb[i]), 64'(e.sb));
          end
        end
        if (clr_pend[i]) sbq[i].delete();
      end
    end
  end

  initial begin
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    repeat (2) @(posedge clk);

    // reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", i, 64'(ov[i]), 64'h0);
      chk("rst_out_ins", i, 64'(oins[i]), 64'h0);
      chk("rst_in_ready", i, 64'(ir[i]), 64'h1);
    end
    chk("rst_stall_cnt", 0, 64'(cnt_a), 64'h0);

    // passthrough with out_ready=1
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h2001000A, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h8C020004, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("pass_first_pc", i, 64'(opc[i]), 64'h100);
      chk("pass_in_ready", i, 64'(ir[i]), 64'h1);
    end
    idle(1'b1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("pass_second_ins", i, 64'(oins[i]), 64'h8C020004);
    idle(1'b1);

    // back-pressure into the skid entry
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h11, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h22, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h33, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_full", 0, 64'(ir[0]), 64'h0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h33, 1'b0);
    @(negedge clk);
    chk("bp_stall_cnt", 0, 64'(cnt_a), 64'h3);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1, 32'h108, 32'h33, 1'b0);
    repeat (3) idle(1'b1);

    // flush while full with an offered entry
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h44, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h55, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h66, 1'b1);
    idle(1'b0);
    @(negedge clk);
    chk("flush_out_valid", 0, 64'(ov[0]), 64'h0);
    chk("flush_in_ready", 0, 64'(ir[0]), 64'h1);
    chk("flush_out_ins", 0, 64'(oins[0]), 64'h0);
    repeat (3) idle(1'b1);

    // saturation of the 4-bit counter, then reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 22; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(4 * k), 32'(k), 1'b0);
    @(negedge clk);
    chk("sat_stall_cnt", 0, 64'(cnt_a), 64'hF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    chk("rst_clears_cnt", 0, 64'(cnt_a), 64'h0);

    // combinational in_ready without skid
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h77, 1'b0);
    @(negedge clk);
    chk("noskid_ready_empty", 1, 64'(ir[1]), 64'h1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h304, 32'h88, 1'b0);
    @(negedge clk);
    chk("noskid_ready_held", 1, 64'(ir[1]), 64'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h308 + 32'(4 * k), 32'h90 + 32'(k), 1'b1);
      @(negedge clk);
      chk("noskid_sustain_ready", 1, 64'(ir[1]), 64'h1);
    end
    repeat (3) idle(1'b1);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
           $urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(0, 1)));
    end
    repeat (4) idle(1'b1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
